// File: rtl/seg7_scan_if.sv
`default_nettype none
// seg7_scan_if: scanned 7-segment bus plus the reconstructed display state.
// Rev 1.0 - initial release
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 8
);
   logic [NUM_DIGITS-1:0]   an;
   logic [7:0]              seg;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp_out;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    update;
   logic                    bad_pattern;
   logic                    frame_done;

   modport master (
      output an, seg,
      input  digits, dp_out, digit_valid, update, bad_pattern, frame_done
   );

   modport slave (
      input  an, seg,
      output digits, dp_out, digit_valid, update, bad_pattern, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_reader.sv
`default_nettype none
// seg7_scan_reader: rebuilds per-position hex digit and dp from a scanned 7-seg bus.
// Option SEG7_BLANK_DETECT_EN: all-segments-off is a legal blank.  Rev 1.0
module seg7_scan_reader #(
   parameter int NUM_DIGITS     = 8,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  wire logic  clk,
   input  wire logic  rst,
   seg7_scan_if.slave bus
);
   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t                state;
   state_t                start_state;
   logic [NUM_DIGITS-1:0] an_r;
   logic [NUM_DIGITS-1:0] prev_an;
   logic [NUM_DIGITS-1:0] mask;
   logic [NUM_DIGITS-1:0] mask_base;
   logic [NUM_DIGITS-1:0] sel;
   logic [7:0]            seg_r;
   logic [7:0]            prev_seg;
   logic [CNT_W-1:0]      cnt;
   logic [TO_W-1:0]       tcnt;
   logic                  legal;
   logic                  same;
   logic                  timed_out;
   logic                  hit;
   logic                  blank;
   logic [3:0]            value;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40:   decode = {1'b1, 4'h0};
         7'h79:   decode = {1'b1, 4'h1};
         7'h24:   decode = {1'b1, 4'h2};
         7'h30:   decode = {1'b1, 4'h3};
         7'h19:   decode = {1'b1, 4'h4};
         7'h12:   decode = {1'b1, 4'h5};
         7'h02:   decode = {1'b1, 4'h6};
         7'h78:   decode = {1'b1, 4'h7};
         7'h00:   decode = {1'b1, 4'h8};
         7'h18:   decode = {1'b1, 4'h9};
         7'h08:   decode = {1'b1, 4'hA};
         7'h03:   decode = {1'b1, 4'hB};
         7'h46:   decode = {1'b1, 4'hC};
         7'h21:   decode = {1'b1, 4'hD};
         7'h06:   decode = {1'b1, 4'hE};
         7'h0E:   decode = {1'b1, 4'hF};
         default: decode = 5'h00;
      endcase
   endfunction

   // The captured sample is the stable one now sitting in prev_*.
   always_comb begin
      legal       = $onehot(~an_r);
      same        = (an_r == prev_an) && (seg_r == prev_seg);
      start_state = IDLE;
      if (legal) begin
         start_state = (STABLE_CYCLES == 1) ? CAPTURE : SETTLE;
      end
      sel          = ~prev_an;
      {hit, value} = decode(prev_seg[6:0]);
`ifdef SEG7_BLANK_DETECT_EN
      blank        = (prev_seg[6:0] == 7'h7F);
`else
      blank        = 1'b0;
`endif
      timed_out    = (tcnt == TO_LAST);
      mask_base    = (&mask) ? '0 : mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         an_r            <= '1;
         seg_r           <= '1;
         prev_an         <= '1;
         prev_seg        <= '1;
         cnt             <= '0;
         tcnt            <= '0;
         mask            <= '0;
         bus.digits      <= '0;
         bus.dp_out      <= '0;
         bus.digit_valid <= '0;
         bus.update      <= 1'b0;
         bus.bad_pattern <= 1'b0;
         bus.frame_done  <= 1'b0;
      end else begin
         an_r            <= bus.an;
         seg_r           <= bus.seg;
         prev_an         <= an_r;
         prev_seg        <= seg_r;
         bus.update      <= 1'b0;
         bus.bad_pattern <= 1'b0;
         bus.frame_done  <= &mask;
         mask            <= mask_base;

         if (state != CAPTURE) begin
            if (timed_out) begin
               bus.digit_valid <= '0;
               mask            <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               state <= start_state;
               cnt   <= CNT_W'(1);
            end
            SETTLE: begin
               if (!same) begin
                  state <= start_state;
                  cnt   <= CNT_W'(1);
               end else if (cnt == SETTLE_LAST) begin
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CAPTURE: begin
               tcnt <= '0;
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (sel[i]) begin
                     if (hit) begin
                        bus.digits[4*i +: 4] <= value;
                        bus.dp_out[i]        <= ~prev_seg[7];
                        bus.digit_valid[i]   <= 1'b1;
                     end else begin
                        bus.digit_valid[i]   <= 1'b0;
                     end
                  end
               end
               if (hit || blank) begin
                  mask <= mask_base | sel;
               end
               bus.update      <= hit;
               bus.bad_pattern <= !hit && !blank;
               // A sample that changed during this cycle begins its own run.
               state <= same ? HOLD : start_state;
               cnt   <= CNT_W'(1);
            end
            HOLD: begin
               if (!same) begin
                  state <= start_state;
                  cnt   <= CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// tb_seg7_scan_reader: directed + random scan traffic, scoreboarded against a
// cycle-level behavioural model of the display snooper.
module tb_seg7_scan_reader;
   localparam int ND      = 8;
   localparam int STABLE  = 4;
   localparam int TIMEOUT = 20;
`ifdef SEG7_BLANK_DETECT_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] dig;
      logic [7:0]  dp;
      logic [7:0]  val;
      logic        upd;
      logic        bad;
      logic        frm;
   } ev_t;

   typedef struct {
      int         due;
      logic [7:0] an;
      logic [7:0] seg;
   } cap_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n_upd = 0;
   int   n_bad = 0;
   int   n_frm = 0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   ev_t  exp_q [$];
   cap_t pend  [$];

   seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_reader #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (STABLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int lookup(input logic [6:0] c);
      for (int i = 0; i < 16; i++) begin
         if (glyph[i] == c) return i;
      end
      return -1;
   endfunction

   function automatic int lowpos(input logic [7:0] a);
      for (int i = 0; i < ND; i++) begin
         if (!a[i]) return i;
      end
      return 0;
   endfunction

   // Reference model: a legal sample held for STABLE consecutive clocks is
   // captured once per run; its result is visible two clocks after the run's
   // STABLE-th sample.
   logic [31:0] m_dig;
   logic [7:0]  m_dp, m_val, m_mask, old_val;
   logic [15:0] prev_s, s;
   logic        e_upd, e_bad, e_frm;
   int          run, last_cap, idx, v;
   cap_t        p;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         m_dig    = '0;
         m_dp     = '0;
         m_val    = '0;
         m_mask   = '0;
         prev_s   = 16'hFFFF;
         run      = 0;
         last_cap = cyc;
         pend.delete();
      end else begin
         e_frm = (m_mask == 8'hFF);
         if (e_frm) m_mask = '0;
         e_upd   = 1'b0;
         e_bad   = 1'b0;
         old_val = m_val;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            p        = pend.pop_front();
            idx      = lowpos(p.an);
            v        = lookup(p.seg[6:0]);
            last_cap = cyc;
            if (v >= 0) begin
               m_dig[idx*4 +: 4] = 4'(v);
               m_dp[idx]         = ~p.seg[7];
               m_val[idx]        = 1'b1;
               m_mask[idx]       = 1'b1;
               e_upd             = 1'b1;
            end else if (BLANK_EN && p.seg[6:0] == 7'h7F) begin
               m_val[idx]  = 1'b0;
               m_mask[idx] = 1'b1;
            end else begin
               m_val[idx] = 1'b0;
               e_bad      = 1'b1;
            end
         end else if (cyc - last_cap >= TIMEOUT) begin
            m_val  = '0;
            m_mask = '0;
         end
         if (e_upd || e_bad || e_frm || m_val != old_val) begin
            exp_q.push_back('{cyc, m_dig, m_dp, m_val, e_upd, e_bad, e_frm});
         end
         s = {bus.an, bus.seg};
         if (s != prev_s) run = 1;
         else if (run < 1000) run = run + 1;
         prev_s = s;
         if (run == STABLE && $countones(~bus.an) == 1) begin
            pend.push_back('{cyc + 2, bus.an, bus.seg});
         end
      end
   end

   // Monitor: every visible DUT event is matched against the next expected one.
   logic [7:0] mon_val = '0;
   ev_t        e;

   always @(negedge clk) begin
      if (rst) begin
         mon_val = '0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e      = exp_q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL missed_event at cyc=%0d: required event at cyc=%0d not seen", cyc, e.cyc);
         end
         if (bus.update || bus.bad_pattern || bus.frame_done || bus.digit_valid != mon_val) begin
            checks = checks + 1;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               errors = errors + 1;
               $display("FAIL unexpected_event cyc=%0d actual digits=%h dp=%h valid=%h upd=%b bad=%b frame=%b",
                        cyc, bus.digits, bus.dp_out, bus.digit_valid, bus.update, bus.bad_pattern, bus.frame_done);
            end else begin
               e = exp_q.pop_front();
               if (bus.digits !== e.dig || bus.dp_out !== e.dp || bus.digit_valid !== e.val ||
                   bus.update !== e.upd || bus.bad_pattern !== e.bad || bus.frame_done !== e.frm) begin
                  errors = errors + 1;
                  $display("FAIL event cyc=%0d actual digits=%h dp=%h valid=%h upd=%b bad=%b frame=%b required digits=%h dp=%h valid=%h upd=%b bad=%b frame=%b",
                           cyc, bus.digits, bus.dp_out, bus.digit_valid, bus.update, bus.bad_pattern, bus.frame_done,
                           e.dig, e.dp, e.val, e.upd, e.bad, e.frm);
               end
            end
         end
         mon_val = bus.digit_valid;
         if (bus.update)      n_upd = n_upd + 1;
         if (bus.bad_pattern) n_bad = n_bad + 1;
         if (bus.frame_done)  n_frm = n_frm + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks = checks + 1;
      if (got !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%h required=%h", name, got, req);
      end
   endtask

   task automatic hold(input logic [7:0] a, input logic [7:0] sg, input int n);
      bus.an  = a;
      bus.seg = sg;
      repeat (n) @(negedge clk);
   endtask

   int         u0, b0, f0, r;
   logic [7:0] a, sg;
   logic [2:0] pos;

   initial begin
      bus.an  = 8'hFF;
      bus.seg = 8'hFF;
      repeat (3) @(negedge clk);
      #1;
      check("reset_state", {bus.digits[23:0], bus.dp_out}, 32'h0);
      check("reset_flags", {bus.digits[31:24], bus.digit_valid, 5'd0, bus.update, bus.bad_pattern, bus.frame_done, 8'd0}, 32'h0);
      rst = 1'b0;

      // single digit on position 0
      u0 = n_upd;
      hold(8'hFE, 8'hC0, 10); #1;
      check("t1_digit0", {20'd0, bus.digits[3:0], bus.digit_valid}, 32'h0000_0001);
      check("t1_dp", 32'(bus.dp_out), 32'h0);
      check("t1_update_once", 32'(n_upd - u0), 32'd1);

      // dp lit with F, then 8 without dp
      u0 = n_upd;
      hold(8'hFB, 8'h0E, 8); #1;
      check("t2_F_dp", {27'd0, bus.digits[11:8], bus.dp_out[2]}, {27'd0, 4'hF, 1'b1});
      hold(8'hFB, 8'h80, 8); #1;
      check("t2_8_nodp", {27'd0, bus.digits[11:8], bus.dp_out[2]}, {27'd0, 4'h8, 1'b0});
      check("t2_update_twice", 32'(n_upd - u0), 32'd2);

      // flicker never settles
      u0 = n_upd;
      for (int i = 0; i < 2; i++) begin
         hold(8'hFD, 8'hA4, 2);
         hold(8'hFD, 8'hB0, 2);
      end
      #1;
      check("t3_no_update_flicker", 32'(n_upd - u0), 32'd0);
      hold(8'hFD, 8'hB0, 8); #1;
      check("t3_digit1", 32'(bus.digits[7:4]), 32'h3);

      // all segments off
      b0 = n_bad;
      hold(8'hFE, 8'hFF, 10); #1;
      check("t4_valid0_clear", 32'(bus.digit_valid[0]), 32'h0);
      check("t4_bad_count", 32'(n_bad - b0), BLANK_EN ? 32'd0 : 32'd1);

      // full scan of glyphs 1..8
      rst = 1'b1;
      hold(8'hFF, 8'hFF, 2);
      rst = 1'b0;
      f0 = n_frm;
      for (int i = 0; i < ND; i++) begin
         a = ~(8'h01 << i);
         hold(a, {1'b1, glyph[i+1]}, 6);
      end
      #1;
      u0 = n_upd;
      hold(8'hFC, 8'hF9, 10); #1;
      check("t5_digits", bus.digits, 32'h8765_4321);
      check("t5_valid", 32'(bus.digit_valid), 32'hFF);
      check("t5_frame_once", 32'(n_frm - f0), 32'd1);
      check("t5_two_low_no_capture", 32'(n_upd - u0), 32'd0);

      // random scan traffic
      for (int i = 0; i < 400; i++) begin
         r   = int'($urandom_range(0, 9));
         pos = 3'($urandom_range(0, 7));
         a   = 8'hFF;
         a[pos] = 1'b0;
         if (r == 0) a = 8'hFF;
         if (r == 1) a[3'($urandom_range(0, 7))] = 1'b0;
         sg = {1'($urandom_range(0, 1)), glyph[4'($urandom_range(0, 15))]};
         if (r == 2) sg = 8'($urandom);
         if (r == 3) sg = 8'hFF;
         hold(a, sg, int'($urandom_range(1, 8)));
      end

      // timeout after a single capture
      hold(8'hFF, 8'hFF, 2);
      hold(8'hFE, 8'h99, 6); #1;
      check("t6_valid_after_capture", 32'(bus.digit_valid[0]), 32'h1);
      hold(8'hFF, 8'hFF, 19); #1;
      check("t6_valid_before_timeout", 32'(bus.digit_valid[0]), 32'h1);
      hold(8'hFF, 8'hFF, 1); #1;
      check("t6_valid_timed_out", 32'(bus.digit_valid), 32'h0);
      check("t6_digit_retained", 32'(bus.digits[3:0]), 32'h4);

      // reset while settling
      hold(8'hFD, 8'hF9, 3);
      rst    = 1'b1;
      bus.an = 8'hFF;
      @(negedge clk); #1;
      check("rst_mid_settle", {bus.digits[23:0], bus.dp_out}, 32'h0);
      check("rst_mid_settle_flags", {bus.digits[31:24], bus.digit_valid, 5'd0, bus.update, bus.bad_pattern, bus.frame_done, 8'd0}, 32'h0);
      rst = 1'b0;
      hold(8'hFF, 8'hFF, 12); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
